// File: rtl/downsample_pack_fifo_pkg.sv
// Shared constants for the 128-to-256 packing FIFO: beat/word widths, storage depth,
// almost-full level and the RAM implementation target.
package downsample_pack_fifo_pkg;

    localparam int DATA_W                = 128;
    localparam int DATA_R                = 2 * DATA_W;
    localparam int DEPTH_R               = 10;
    localparam int WORD_NUM              = 2 ** DEPTH_R;
    localparam int ALMOST_FULL_THRESHOLD = 1000;

    typedef enum logic [0:0] {
        DEV_SIMULATION = 1'b0,
        DEV_XILINX     = 1'b1
    } device_e;

    localparam device_e DEVICE = DEV_SIMULATION;

endpackage

// File: rtl/downsample_pack_fifo_ram.sv
// Simple dual-port word store: one write port, one registered read port whose
// output register resets to zero and holds its value when no read is issued.
module pack_fifo_ram
    import downsample_pack_fifo_pkg::*;
#(
    parameter device_e DEV = DEVICE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [DEPTH_R-1:0] waddr,
    input  logic [DATA_R-1:0]  wdata,
    input  logic               re,
    input  logic [DEPTH_R-1:0] raddr,
    output logic [DATA_R-1:0]  rdata
);

    generate
        if (DEV == DEV_XILINX) begin : g_xilinx
            // Block RAM with its output register absorbing the read-data reset.
            (* ram_style = "block" *) logic [DATA_R-1:0] mem [WORD_NUM];

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_simulation
            logic [DATA_R-1:0] mem [WORD_NUM];

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/downsample_pack_fifo.sv
// Packs pairs of 128-bit beats (first beat in the low half) into 256-bit words and
// buffers them; supports zero-filled partial-word flush and count-based flags.
module downsample_pack_fifo
    import downsample_pack_fifo_pkg::*;
(
    input  logic               system_clk,
    input  logic               rst,
    input  logic               i_wren,
    input  logic [DATA_W-1:0]  i_wrdata,
    input  logic               i_flush,
    output logic               o_full,
    output logic               o_almost_full,
    output logic               o_partial,
    input  logic               i_rden,
    output logic [DATA_R-1:0]  o_rddata,
    output logic               o_rdvalid,
    output logic               o_empty,
    output logic               o_almost_empty,
    input  logic [DEPTH_R:0]   i_almost_empty_threshold,
    output logic [DEPTH_R:0]   o_word_count
);

    localparam logic [DEPTH_R-1:0] PTR_ONE    = {{(DEPTH_R-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_R:0]   CNT_ONE    = {{DEPTH_R{1'b0}}, 1'b1};
    localparam logic [DEPTH_R:0]   CNT_FULL   = (DEPTH_R+1)'(WORD_NUM);
    localparam logic [DEPTH_R:0]   CNT_ALMOST = (DEPTH_R+1)'(ALMOST_FULL_THRESHOLD);

    // Handshake: a beat is taken on any cycle with i_wren && !o_full (i_flush is
    // likewise ignored while full); a word is popped on i_rden && !o_empty and is
    // presented on o_rddata with o_rdvalid exactly one cycle later, otherwise held.

    logic [DEPTH_R-1:0] wrptr;
    logic [DEPTH_R-1:0] rdptr;
    logic [DEPTH_R:0]   word_count;
    logic               half_sel;
    logic [DATA_W-1:0]  pack_lo;

    logic               wren;
    logic               flush_ok;
    logic               rden;
    logic               commit;
    logic               load_lo;
    logic [DATA_R-1:0]  commit_word;

    assign wren     = i_wren & ~o_full;
    assign flush_ok = i_flush & ~o_full;
    assign rden     = i_rden & ~o_empty;

    always_comb begin
        commit      = 1'b0;
        load_lo     = 1'b0;
        commit_word = '0;
        if (wren && half_sel) begin
            commit      = 1'b1;
            commit_word = {i_wrdata, pack_lo};
        end else if (wren && flush_ok) begin
            // Lone beat flushed in its own cycle bypasses the pack register.
            commit      = 1'b1;
            commit_word = {{DATA_W{1'b0}}, i_wrdata};
        end else if (wren) begin
            load_lo     = 1'b1;
        end else if (flush_ok && half_sel) begin
            commit      = 1'b1;
            commit_word = {{DATA_W{1'b0}}, pack_lo};
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            wrptr      <= '0;
            rdptr      <= '0;
            word_count <= '0;
            half_sel   <= 1'b0;
            pack_lo    <= '0;
            o_rdvalid  <= 1'b0;
        end else begin
            o_rdvalid <= rden;
            if (load_lo) begin
                pack_lo  <= i_wrdata;
                half_sel <= 1'b1;
            end else if (commit) begin
                half_sel <= 1'b0;
            end
            if (commit) begin
                wrptr <= wrptr + PTR_ONE;
            end
            if (rden) begin
                rdptr <= rdptr + PTR_ONE;
            end
            case ({commit, rden})
                2'b10:   word_count <= word_count + CNT_ONE;
                2'b01:   word_count <= word_count - CNT_ONE;
                default: word_count <= word_count;
            endcase
        end
    end

    pack_fifo_ram #(
        .DEV (DEVICE)
    ) u_ram (
        .clk   (system_clk),
        .rst   (rst),
        .we    (commit),
        .waddr (wrptr),
        .wdata (commit_word),
        .re    (rden),
        .raddr (rdptr),
        .rdata (o_rddata)
    );

    assign o_word_count   = word_count;
    assign o_partial      = half_sel;
    assign o_full         = (word_count == CNT_FULL);
    assign o_empty        = (word_count == '0);
    assign o_almost_full  = (word_count >= CNT_ALMOST);
    assign o_almost_empty = (word_count < i_almost_empty_threshold);

endmodule

// File: tb/tb_downsample_pack_fifo.sv
// Bench for downsample_pack_fifo: table-driven short vectors, then fill/wrap,
// simultaneous commit+read and mid-stream reset sequences with a word scoreboard.
module tb_downsample_pack_fifo;
    import downsample_pack_fifo_pkg::*;

    logic               system_clk;
    logic               rst;
    logic               i_wren;
    logic [DATA_W-1:0]  i_wrdata;
    logic               i_flush;
    logic               o_full;
    logic               o_almost_full;
    logic               o_partial;
    logic               i_rden;
    logic [DATA_R-1:0]  o_rddata;
    logic               o_rdvalid;
    logic               o_empty;
    logic               o_almost_empty;
    logic [DEPTH_R:0]   i_almost_empty_threshold;
    logic [DEPTH_R:0]   o_word_count;

    downsample_pack_fifo dut (
        .system_clk               (system_clk),
        .rst                      (rst),
        .i_wren                   (i_wren),
        .i_wrdata                 (i_wrdata),
        .i_flush                  (i_flush),
        .o_full                   (o_full),
        .o_almost_full            (o_almost_full),
        .o_partial                (o_partial),
        .i_rden                   (i_rden),
        .o_rddata                 (o_rddata),
        .o_rdvalid                (o_rdvalid),
        .o_empty                  (o_empty),
        .o_almost_empty           (o_almost_empty),
        .i_almost_empty_threshold (i_almost_empty_threshold),
        .o_word_count             (o_word_count)
    );

    // clock / reset
    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    // checking state
    int                n_checks;
    int                n_fail;
    logic [DATA_R-1:0] exp_q[$];
    int                m_count;
    logic              m_half;
    logic [DATA_W-1:0] m_lo;
    logic [DATA_R-1:0] last_rd;

    typedef struct {
        logic              wr;
        logic [DATA_W-1:0] d;
        logic              fl;
        logic              rd;
        int                cnt;
        logic              part;
        logic              emp;
        logic              rv;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [DATA_R-1:0] act, input logic [DATA_R-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one clock of stimulus; model predicts commits/flags, scoreboard pops read words
    task automatic cyc(input logic wr, input logic [DATA_W-1:0] d, input logic fl, input logic rd);
        logic w;
        logic f;
        logic r;
        logic c;
        w = wr && (m_count != WORD_NUM);
        f = fl && (m_count != WORD_NUM);
        r = rd && (m_count != 0);
        c = 1'b0;
        i_wren   = wr;
        i_wrdata = d;
        i_flush  = fl;
        i_rden   = rd;
        @(posedge system_clk);
        #1;
        if (w && m_half) begin
            exp_q.push_back({d, m_lo});
            m_half = 1'b0;
            c = 1'b1;
        end else if (w && f) begin
            exp_q.push_back({{DATA_W{1'b0}}, d});
            c = 1'b1;
        end else if (w) begin
            m_lo   = d;
            m_half = 1'b1;
        end else if (f && m_half) begin
            exp_q.push_back({{DATA_W{1'b0}}, m_lo});
            m_half = 1'b0;
            c = 1'b1;
        end
        m_count = m_count + int'(c) - int'(r);
        chk("word_count", DATA_R'(o_word_count), DATA_R'(m_count));
        chk("partial", DATA_R'(o_partial), DATA_R'(m_half));
        chk("full", DATA_R'(o_full), DATA_R'(m_count == WORD_NUM));
        chk("empty", DATA_R'(o_empty), DATA_R'(m_count == 0));
        chk("almost_full", DATA_R'(o_almost_full), DATA_R'(m_count >= ALMOST_FULL_THRESHOLD));
        chk("almost_empty", DATA_R'(o_almost_empty), DATA_R'(m_count < int'(i_almost_empty_threshold)));
        chk("rdvalid", DATA_R'(o_rdvalid), DATA_R'(r));
        if (o_rdvalid) begin
            if (exp_q.size() == 0) begin
                chk("rdvalid_without_word", DATA_R'(o_rdvalid), '0);
            end else begin
                chk("rddata", o_rddata, exp_q.pop_front());
            end
            last_rd = o_rddata;
        end else begin
            chk("rddata_hold", o_rddata, last_rd);
        end
    endtask

    task automatic do_reset(input logic rd_during);
        rst      = 1'b1;
        i_wren   = 1'b1;
        i_wrdata = 128'h1234;
        i_flush  = 1'b0;
        i_rden   = rd_during;
        @(posedge system_clk);
        #1;
        rst     = 1'b0;
        i_wren  = 1'b0;
        i_rden  = 1'b0;
        m_count = 0;
        m_half  = 1'b0;
        m_lo    = '0;
        last_rd = '0;
        exp_q.delete();
        chk("rst_count", DATA_R'(o_word_count), '0);
        chk("rst_empty", DATA_R'(o_empty), DATA_R'(1'b1));
        chk("rst_full", DATA_R'(o_full), '0);
        chk("rst_partial", DATA_R'(o_partial), '0);
        chk("rst_rdvalid", DATA_R'(o_rdvalid), '0);
        chk("rst_rddata", o_rddata, '0);
        chk("rst_almost_empty", DATA_R'(o_almost_empty), DATA_R'(1'b1));
    endtask

    task automatic drain();
        for (int k = 0; k < WORD_NUM + 16 && m_count > 0; k++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("drain_count", DATA_R'(o_word_count), '0);
        chk("drain_empty", DATA_R'(o_empty), DATA_R'(1'b1));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_almost_empty_threshold = 11'd1;
        m_count = 0;
        m_half  = 1'b0;
        m_lo    = '0;
        last_rd = '0;

        vecs[0]  = '{1'b1, 128'hA, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 128'hB, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 128'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 128'h0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 128'h5, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 128'h0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 128'h7, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 128'h1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 128'h2, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 128'h0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 128'h0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 128'h0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b1};

        do_reset(1'b0);

        // basic pack, flush and flush-with-write vectors
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].wr, vecs[i].d, vecs[i].fl, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), DATA_R'(o_word_count), DATA_R'(vecs[i].cnt));
            chk($sformatf("vec%0d_partial", i), DATA_R'(o_partial), DATA_R'(vecs[i].part));
            chk($sformatf("vec%0d_empty", i), DATA_R'(o_empty), DATA_R'(vecs[i].emp));
            chk($sformatf("vec%0d_rdvalid", i), DATA_R'(o_rdvalid), DATA_R'(vecs[i].rv));
        end
        chk("vec_queue_empty", DATA_R'(exp_q.size()), '0);

        // fill to full, then push extra beats that must be dropped
        for (int i = 0; i < 2 * WORD_NUM; i++) begin
            cyc(1'b1, {96'hC0DE_0000_0000_0000_0000_0000, 32'(i)}, 1'b0, 1'b0);
        end
        chk("fill_full", DATA_R'(o_full), DATA_R'(1'b1));
        chk("fill_count", DATA_R'(o_word_count), DATA_R'(WORD_NUM));
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 128'hDEAD_0000 + 128'(i), 1'b0, 1'b0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("full_drop_partial", DATA_R'(o_partial), '0);
        chk("full_drop_count", DATA_R'(o_word_count), DATA_R'(WORD_NUM));
        cyc(1'b0, '0, 1'b0, 1'b1);
        // a lone flushed beat proves the dropped beats never reached the pack register
        cyc(1'b1, 128'hBEEF, 1'b1, 1'b0);
        chk("refull_count", DATA_R'(o_word_count), DATA_R'(WORD_NUM));
        drain();

        // streaming across the pointer wrap
        for (int i = 0; i < 2400; i++) begin
            cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'(i % 2));
        end
        drain();

        // simultaneous commit and read at count 3
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 128'h300 + 128'(i), 1'b0, 1'b0);
        end
        chk("steady_count", DATA_R'(o_word_count), DATA_R'(3));
        for (int k = 0; k < 8; k++) begin
            i_almost_empty_threshold = (k % 2 == 1) ? 11'd4 : 11'd3;
            cyc(1'b1, 128'h400 + 128'(k), 1'b1, 1'b1);
            chk("steady_hold_count", DATA_R'(o_word_count), DATA_R'(3));
            chk("steady_almost_empty", DATA_R'(o_almost_empty), DATA_R'(k % 2 == 1));
        end
        i_almost_empty_threshold = 11'd1;
        cyc(1'b1, 128'h501, 1'b0, 1'b1);
        cyc(1'b1, 128'h502, 1'b0, 1'b1);
        chk("pair_read_count", DATA_R'(o_word_count), DATA_R'(2));

        // reset mid-stream with a pending half
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 128'h600 + 128'(i), 1'b0, 1'b0);
        end
        chk("pre_rst_count", DATA_R'(o_word_count), DATA_R'(5));
        chk("pre_rst_partial", DATA_R'(o_partial), DATA_R'(1'b1));
        do_reset(1'b1);
        cyc(1'b1, 128'h71, 1'b0, 1'b0);
        cyc(1'b1, 128'h72, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("post_rst_data", o_rddata, {128'h72, 128'h71});
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("final_queue_empty", DATA_R'(exp_q.size()), '0);
        chk("final_empty", DATA_R'(o_empty), DATA_R'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
